// File: rtl/divider_seq_pkg.sv
// rtl/divider_seq_pkg.sv - shared widths, state encodings and counter sizing for divider_seq
package divider_seq_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  function automatic int cnt_width(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/divider_seq_if.sv
// rtl/divider_seq_if.sv - start/done request and result bundle between controller and divider
interface divider_seq_if
  import divider_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) ();

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic          dbz;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  modport master (output start, dividend, divisor,
                  input  busy, done, dbz, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, dbz, quotient, remainder);

endinterface

// File: rtl/divider_seq_div_step.sv
// rtl/divider_seq_div_step.sv - one restoring-division step: shift in a dividend bit, trial-subtract
module divider_seq_div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  // r_i stays below 2^VW, so the shifted value fits VW+1 bits and bit VW+1 is a clean sign.
  logic [VW+1:0] diff;

  assign diff    = {r_i, q_msb_i} - {2'b00, d_i};
  assign q_bit_o = ~diff[VW+1];
  assign r_o     = q_bit_o ? diff[VW:0] : {r_i[VW-1:0], q_msb_i};

endmodule

// File: rtl/divider_seq.sv
// rtl/divider_seq.sv - radix-2 sequential restoring divider; DIV_ONE_BYPASS_EN shortcuts divisor==1
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  divider_seq_if.slave bus
);

  localparam int CW = cnt_width(DW);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_r;
  logic          step_qb;
  logic          accept;

  divider_seq_div_step #(.VW(VW)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_qb)
  );

  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      ST_IDLE:   ;
      ST_DIVIDE: begin
        r_d   = step_r;
        q_d   = {q_q[DW-2:0], step_qb};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          quo_d   = {q_q[DW-2:0], step_qb};
          rem_d   = step_r[VW-1:0];
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // A start seen in DONE overrides the return to IDLE; done still pulses this cycle.
    if (accept) begin
      q_d   = bus.dividend;
      d_d   = bus.divisor;
      r_d   = '0;
      cnt_d = CW'(DW);
      dbz_d = 1'b0;
      if (bus.divisor == '0) begin
        state_d = ST_DONE;
        quo_d   = '1;
        rem_d   = '0;
        dbz_d   = 1'b1;
      end
`ifdef DIV_ONE_BYPASS_EN
      else if (bus.divisor == VW'(1)) begin
        state_d = ST_DONE;
        quo_d   = bus.dividend;
        rem_d   = '0;
      end
`endif
      else begin
        state_d = ST_DIVIDE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy      = (state_q == ST_DIVIDE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.dbz       = dbz_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_divider_seq.sv
// tb/tb_divider_seq.sv - directed and randomized checks of divider_seq against an arithmetic model
module tb_divider_seq;
  import divider_seq_pkg::*;

  localparam int DW = DW_DEF;
  localparam int VW = VW_DEF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  divider_seq_if #(.DW(DW), .VW(VW)) bus ();
  divider_seq #(.DW(DW), .VW(VW)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

`ifdef DIV_ONE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; latency counted in edges after the accepting edge.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int z, output int lat);
    if (b == 0) begin
      q = (1 << DW) - 1; r = 0; z = 1; lat = 0;
    end else begin
      q = a / b; r = a % b; z = 0;
      lat = (BYPASS && b == 1) ? 0 : DW;
    end
  endtask

  task automatic run_op(input string tag, input int a, input int b, input bit poke);
    int q, r, z, lat, n, busy_n;
    model(a, b, q, r, z, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = DW'(a); bus.divisor = VW'(b);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = DW'($urandom); bus.divisor = VW'($urandom);
    n = 0; busy_n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      if (poke && n == 2) begin
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, bus.done, 1);
    check({tag, ".latency"}, n, lat);
    check({tag, ".busy_cycles"}, busy_n, lat);
    check({tag, ".busy_at_done"}, bus.busy, 0);
    check({tag, ".quotient"}, bus.quotient, q);
    check({tag, ".remainder"}, bus.remainder, r);
    check({tag, ".dbz"}, bus.dbz, z);
  endtask

  task automatic idle_hold(input string tag, input int cycles, input int q, input int r, input int z);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check({tag, ".done_low"}, bus.done, 0);
      check({tag, ".busy_low"}, bus.busy, 0);
      check({tag, ".q_held"}, bus.quotient, q);
      check({tag, ".r_held"}, bus.remainder, r);
      check({tag, ".dbz_held"}, bus.dbz, z);
    end
  endtask

  initial begin
    int a, b, q, r, z, lat;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.done, 0);
    check("reset.dbz", bus.dbz, 0);
    check("reset.quotient", bus.quotient, 0);
    check("reset.remainder", bus.remainder, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("d200_7", 200, 7, 1'b0);
    idle_hold("d200_7", 1, 28, 4, 0);

    run_op("d255_15", 255, 15, 1'b0);
    idle_hold("d255_15", 3, 17, 0, 0);
    run_op("d5_9", 5, 9, 1'b0);

    run_op("d100_0", 100, 0, 1'b0);
    idle_hold("d100_0", 2, 255, 0, 1);
    run_op("d100_3", 100, 3, 1'b0);
    idle_hold("d100_3", 1, 33, 1, 0);

    run_op("d200_7_poke", 200, 7, 1'b1);

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 4'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort.busy", bus.busy, 0);
    check("abort.done", bus.done, 0);
    check("abort.dbz", bus.dbz, 0);
    check("abort.quotient", bus.quotient, 0);
    check("abort.remainder", bus.remainder, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check("abort.no_done", bus.done, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    idle_hold("abort.after", 2, 0, 0, 0);
    run_op("d9_2", 9, 2, 1'b0);

    run_op("d173_1", 173, 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(0, (1 << DW) - 1));
      b = (i % 7 == 0) ? 0 : (i % 5 == 0) ? 1 : int'($urandom_range(0, (1 << VW) - 1));
      run_op($sformatf("rand%0d", i), a, b, i[0]);
      if ($urandom_range(0, 1) == 1) begin
        model(a, b, q, r, z, lat);
        idle_hold($sformatf("rand%0d", i), 1, q, r, z);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_seq.md
Name: divider_seq

Overview:
- Sequential unsigned restoring divider; inverse companion of the shift-add multiplier datapath.
- Divides an 8-bit dividend by a 4-bit divisor; produces an 8-bit quotient and a 4-bit remainder.
- Radix-2, one quotient bit per clock; start/done handshake toward the top-level controller.
- Same arithmetic slice of the design as the multiplier; shares operand registers and style.

Parameters:
- DW, 8, dividend and quotient width.
- VW, 4, divisor and remainder width; VW < DW required.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  DW  numerator, latched when start is accepted.
- divisor  input  VW  denominator, latched when start is accepted.
- busy  output  1  high while in DIVIDE.
- done  output  1  one-cycle pulse when results become valid.
- dbz  output  1  divide-by-zero flag, valid with done, held with results.
- quotient  output  DW  result, held until the next accepted start.
- remainder  output  VW  result, held until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, dbz=0.
  - quotient=0, remainder=0; internal registers cleared.
  - Aborts any operation in progress; no done is issued.
- States: IDLE, DIVIDE, DONE.
- IDLE / DONE, start=1 at edge k:
  - Latch dividend into Q and divisor into D; clear partial remainder R (VW+1 bits).
  - Load iteration counter with DW; clear dbz.
  - If divisor==0: go to DONE with quotient={DW{1'b1}}, remainder=0, dbz=1. done is high the cycle after edge k.
  - Otherwise go to DIVIDE.
- DIVIDE, each edge:
  - Shift {R,Q} left by 1 (Q msb enters R lsb); T = R_shifted - {1'b0,D}.
  - If T is non-negative: R=T, Q lsb=1; else Q lsb=0.
  - Decrement counter; after the DW-th step go to DONE and copy Q to quotient and R[VW-1:0] to remainder.
- Latency: done is high in the cycle after edge k+DW, i.e. DW+1 cycles after start is sampled. busy=1 for exactly DW cycles.
- DONE: done=1 for one cycle, then IDLE. start in DONE is accepted exactly as in IDLE; done still pulses that cycle.
- start while busy is ignored; operands may change freely while busy.
- R never exceeds VW bits after a step; remainder < divisor is guaranteed.

Optional Feature:
- Macro: DIV_ONE_BYPASS_EN.
- Defined: divisor==1 at accept goes straight to DONE with quotient=dividend, remainder=0, dbz=0; latency is 1 cycle.
- Undefined: divisor==1 takes the normal DW-cycle path. Results are identical either way; only latency differs.

Decomposition:
- Shared header/package:
  - DW/VW defaults.
  - State encodings IDLE=2'd0, DIVIDE=2'd1, DONE=2'd2.
  - Counter width constant $clog2(DW+1).
- Sub-module div_step: combinational VW+1-bit shift/trial-subtract.
  - Inputs: R, Q msb, D.
  - Outputs: next R, quotient bit.
  - Instantiated once.

Test Plan:
- 200/7, start 1 cycle -> busy 8 cycles; done pulse at cycle 9; quotient=28, remainder=4, dbz=0.
- 255/15 -> quotient=17, remainder=0; then 5/9 -> quotient=0, remainder=5; earlier results hold until second start.
- 100/0 -> done the cycle after start; dbz=1, quotient=8'hFF, remainder=0; next start 100/3 clears dbz -> 33, 1.
- Start 200/7, pulse start with 50/5 at cycle 3 -> ignored; result still 28/4.
- rst low at cycle 4 of 200/7 -> outputs 0 immediately, no done; new 9/2 after release -> 4/1.
- With DIV_ONE_BYPASS_EN: 173/1 -> done the cycle after start, quotient=173, remainder=0. Without it: same values at cycle 9.
